// File: rtl/ctrl_encode_def.sv
// Shared encodings and default latencies for the hazard / mult-div control slice.
package ctrl_encode_def;

    typedef enum logic {
        RUN    = 1'b0,
        MDBUSY = 1'b1
    } mdState_t;

    localparam int MULT_CYCLES_DEF = 4;
    localparam int DIV_CYCLES_DEF  = 32;
    localparam int MD_CNT_W        = 6;

endpackage

// File: rtl/hazard_md_timer.sv
// Down-counter that times a running mult/div operation.
module hazard_md_timer
    import ctrl_encode_def::*;
(
    input  logic                clk,
    input  logic                rstn,
    input  logic                load,
    input  logic [MD_CNT_W-1:0] loadVal,
    input  logic                dec,
    output logic [MD_CNT_W-1:0] mdCnt,
    output logic                zero
);

    assign zero = (mdCnt == '0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mdCnt <= '0;
        end else if (load) begin
            mdCnt <= loadVal;
        end else if (dec && !zero) begin
            mdCnt <= mdCnt - 1'b1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: load-use and mult/div stalls, branch flushes,
// mult/div latency sequencing and a saturating stall counter.
module hazard_ctrl
    import ctrl_encode_def::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        IDEXMemRead,
    input  logic [4:0]  IDEXRegRt,
    input  logic [4:0]  IFIDRegRs,
    input  logic [4:0]  IFIDRegRt,
    input  logic        IFIDUsesRt,
    input  logic        BranchTaken,
    input  logic        IDEXMd,
    input  logic        IDEXMdIsDiv,
    input  logic        IFIDMd,
    input  logic        IFIDMdRead,
    output logic        PCWrite,
    output logic        IFIDWrite,
    output logic        IFIDFlush,
    output logic        IDEXFlush,
    output logic        MdStart,
    output logic        MdBusy,
    output logic        MdDone,
    output logic [15:0] StallCnt
);

    localparam logic [MD_CNT_W-1:0] MULT_LOAD = MD_CNT_W'(MULT_CYCLES - 1);
    localparam logic [MD_CNT_W-1:0] DIV_LOAD  = MD_CNT_W'(DIV_CYCLES - 1);

    mdState_t            state;
    logic [MD_CNT_W-1:0] mdCnt;
    logic                cntZero;
    logic                loadUse;
    logic                mdHaz;
    logic                stall;

    assign MdBusy  = (state == MDBUSY);
    assign MdStart = (state == RUN) && IDEXMd && !BranchTaken;
    assign MdDone  = MdBusy && cntZero;

    assign loadUse = IDEXMemRead && (IDEXRegRt != 5'd0) &&
                     ((IDEXRegRt == IFIDRegRs) ||
                      (IFIDUsesRt && (IDEXRegRt == IFIDRegRt)));

    assign mdHaz = (IFIDMd || IFIDMdRead) && (MdBusy || MdStart);

    // A taken branch squashes the stalled instruction, so it wins.
    assign stall = (loadUse || mdHaz) && !BranchTaken;

    hazard_md_timer u_timer (
        .clk     (clk),
        .rstn    (rstn),
        .load    (MdStart),
        .loadVal (IDEXMdIsDiv ? DIV_LOAD : MULT_LOAD),
        .dec     (MdBusy),
        .mdCnt   (mdCnt),
        .zero    (cntZero)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= RUN;
        end else begin
            unique case (state)
                RUN:     if (MdStart) state <= MDBUSY;
                MDBUSY:  if (cntZero) state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

    always_comb begin
        PCWrite   = 1'b1;
        IFIDWrite = 1'b1;
        IFIDFlush = 1'b0;
        IDEXFlush = 1'b0;
        unique case (1'b1)
            BranchTaken: begin
                IFIDFlush = 1'b1;
                IDEXFlush = 1'b1;
            end
            stall: begin
                PCWrite   = 1'b0;
                IFIDWrite = 1'b0;
                IDEXFlush = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            StallCnt <= 16'd0;
        end else if (stall && (StallCnt != 16'hFFFF)) begin
            StallCnt <= StallCnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl with directed scenarios and random traffic.
module tb_hazard_ctrl;

    localparam int MC = 4;
    localparam int DC = 32;

    logic        clk = 1'b0;
    logic        rstn;
    logic        IDEXMemRead;
    logic [4:0]  IDEXRegRt;
    logic [4:0]  IFIDRegRs;
    logic [4:0]  IFIDRegRt;
    logic        IFIDUsesRt;
    logic        BranchTaken;
    logic        IDEXMd;
    logic        IDEXMdIsDiv;
    logic        IFIDMd;
    logic        IFIDMdRead;
    logic        PCWrite;
    logic        IFIDWrite;
    logic        IFIDFlush;
    logic        IDEXFlush;
    logic        MdStart;
    logic        MdBusy;
    logic        MdDone;
    logic [15:0] StallCnt;

    int checks = 0;
    int errors = 0;

    // Reference model: remaining busy cycles of the unit and total stalls.
    int busyLeft = 0;
    int stalls   = 0;

    wire [6:0] outs = {PCWrite, IFIDWrite, IFIDFlush, IDEXFlush,
                       MdStart, MdBusy, MdDone};

    hazard_ctrl #(
        .MULT_CYCLES (MC),
        .DIV_CYCLES  (DC)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .IDEXMemRead (IDEXMemRead),
        .IDEXRegRt   (IDEXRegRt),
        .IFIDRegRs   (IFIDRegRs),
        .IFIDRegRt   (IFIDRegRt),
        .IFIDUsesRt  (IFIDUsesRt),
        .BranchTaken (BranchTaken),
        .IDEXMd      (IDEXMd),
        .IDEXMdIsDiv (IDEXMdIsDiv),
        .IFIDMd      (IFIDMd),
        .IFIDMdRead  (IFIDMdRead),
        .PCWrite     (PCWrite),
        .IFIDWrite   (IFIDWrite),
        .IFIDFlush   (IFIDFlush),
        .IDEXFlush   (IDEXFlush),
        .MdStart     (MdStart),
        .MdBusy      (MdBusy),
        .MdDone      (MdDone),
        .StallCnt    (StallCnt)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] model_outs();
        logic lu, st, bz, dn, mdh, stl, br;
        br  = BranchTaken;
        lu  = IDEXMemRead && IDEXRegRt != 0 &&
              (IDEXRegRt == IFIDRegRs ||
               (IFIDUsesRt && IDEXRegRt == IFIDRegRt));
        bz  = busyLeft > 0;
        st  = !bz && IDEXMd && !br;
        dn  = busyLeft == 1;
        mdh = (IFIDMd || IFIDMdRead) && (bz || st);
        stl = (lu || mdh) && !br;
        return {!stl, !stl, br, br || stl, st, bz, dn};
    endfunction

    task automatic tick();
        logic [6:0] e;
        e = model_outs();
        if (!rstn) begin
            busyLeft = 0;
            stalls   = 0;
        end else begin
            if (!e[3 + 0] && 1'b0) stalls = stalls;
            if (e[6] == 1'b0 && stalls < 65535) stalls++;
            if (e[2]) busyLeft = IDEXMdIsDiv ? DC : MC;
            else if (busyLeft > 0) busyLeft--;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        IDEXMemRead = 0; IDEXRegRt = 0; IFIDRegRs = 0; IFIDRegRt = 0;
        IFIDUsesRt = 0; BranchTaken = 0; IDEXMd = 0; IDEXMdIsDiv = 0;
        IFIDMd = 0; IFIDMdRead = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rstn = 1'b0;
        #2;
        checks++;
        if (outs !== 7'b1100000) begin
            errors++;
            $display("FAIL reset_outs got %b want %b", outs, 7'b1100000);
        end
        checks++;
        if (StallCnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_cnt got %0d want 0", StallCnt);
        end
        busyLeft = 0;
        stalls   = 0;
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (outs !== 7'b1100000 || StallCnt !== 16'd0) begin
            errors++;
            $display("FAIL post_reset got %b/%0d want 1100000/0", outs, StallCnt);
        end
    endtask

    task automatic test_load_use();
        IDEXMemRead = 1; IDEXRegRt = 8; IFIDRegRs = 8;
        #1;
        checks++;
        if (outs !== 7'b0001000) begin
            errors++;
            $display("FAIL load_use_outs got %b want 0001000", outs);
        end
        tick();
        clear_inputs();
        #1;
        checks++;
        if (StallCnt !== 16'd1 || outs !== 7'b1100000) begin
            errors++;
            $display("FAIL load_use_cnt got %0d/%b want 1/1100000", StallCnt, outs);
        end
    endtask

    task automatic test_r0_and_rt();
        IDEXMemRead = 1; IDEXRegRt = 0; IFIDRegRs = 0;
        IFIDRegRt = 0; IFIDUsesRt = 1;
        #1;
        checks++;
        if (outs !== 7'b1100000) begin
            errors++;
            $display("FAIL load_r0 got %b want 1100000", outs);
        end
        tick();
        IDEXRegRt = 9; IFIDRegRs = 3; IFIDRegRt = 9; IFIDUsesRt = 0;
        #1;
        checks++;
        if (outs !== 7'b1100000) begin
            errors++;
            $display("FAIL rt_unused got %b want 1100000", outs);
        end
        tick();
        IFIDUsesRt = 1;
        #1;
        checks++;
        if (outs !== 7'b0001000) begin
            errors++;
            $display("FAIL rt_used got %b want 0001000", outs);
        end
        tick();
        clear_inputs();
        #1;
        checks++;
        if (StallCnt !== 16'(stalls) || stalls != 2) begin
            errors++;
            $display("FAIL r0_cnt got %0d want 2", StallCnt);
        end
    endtask

    task automatic test_div_mfhi();
        int s0;
        s0 = stalls;
        IDEXMd = 1; IDEXMdIsDiv = 1; IFIDMdRead = 1;
        #1;
        checks++;
        if (outs !== 7'b0001100) begin
            errors++;
            $display("FAIL div_start got %b want 0001100", outs);
        end
        tick();
        IDEXMd = 0; IDEXMdIsDiv = 0;
        for (int i = 1; i <= DC; i++) begin
            #1;
            checks++;
            if (outs !== {6'b000101, i == DC}) begin
                errors++;
                $display("FAIL div_busy%0d got %b want %b", i, outs,
                         {6'b000101, i == DC});
            end
            tick();
        end
        IFIDMdRead = 0;
        #1;
        checks++;
        if (outs !== 7'b1100000 || StallCnt !== 16'(s0 + 33)) begin
            errors++;
            $display("FAIL div_end got %b/%0d want 1100000/%0d", outs, StallCnt, s0 + 33);
        end
    endtask

    task automatic test_mult_mult();
        IDEXMd = 1; IFIDMd = 1;
        #1;
        checks++;
        if (outs !== 7'b0001100) begin
            errors++;
            $display("FAIL mm_start got %b want 0001100", outs);
        end
        tick();
        IDEXMd = 0;
        for (int i = 1; i <= MC; i++) begin
            #1;
            checks++;
            if (outs !== {6'b000101, i == MC}) begin
                errors++;
                $display("FAIL mm_busy%0d got %b want %b", i, outs,
                         {6'b000101, i == MC});
            end
            tick();
        end
        #1;
        checks++;
        if (outs !== 7'b1100000) begin
            errors++;
            $display("FAIL mm_release got %b want 1100000", outs);
        end
        tick();
        IDEXMd = 1; IFIDMd = 0;
        #1;
        checks++;
        if (outs !== 7'b1100100) begin
            errors++;
            $display("FAIL mm_restart got %b want 1100100", outs);
        end
        tick();
        IDEXMd = 0;
        for (int i = 1; i <= MC; i++) begin
            #1;
            checks++;
            if (outs !== {6'b110001, i == MC}) begin
                errors++;
                $display("FAIL mm_busy2_%0d got %b want %b", i, outs,
                         {6'b110001, i == MC});
            end
            tick();
        end
        #1;
        checks++;
        if (MdBusy !== 1'b0) begin
            errors++;
            $display("FAIL mm_idle got %b want 0", MdBusy);
        end
    endtask

    task automatic test_branch();
        int s0;
        s0 = stalls;
        IDEXMemRead = 1; IDEXRegRt = 8; IFIDRegRs = 8;
        BranchTaken = 1; IDEXMd = 1;
        #1;
        checks++;
        if (outs !== 7'b1111000) begin
            errors++;
            $display("FAIL br_over got %b want 1111000", outs);
        end
        tick();
        clear_inputs();
        #1;
        checks++;
        if (StallCnt !== 16'(s0)) begin
            errors++;
            $display("FAIL br_cnt got %0d want %0d", StallCnt, s0);
        end
        IDEXMd = 1;
        tick();
        IDEXMd = 0; BranchTaken = 1;
        for (int i = 1; i <= MC; i++) begin
            #1;
            checks++;
            if (outs !== {6'b111101, i == MC}) begin
                errors++;
                $display("FAIL br_busy%0d got %b want %b", i, outs,
                         {6'b111101, i == MC});
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid_div();
        IDEXMd = 1; IDEXMdIsDiv = 1;
        tick();
        clear_inputs();
        for (int i = 1; i < 10; i++) tick();
        #1;
        checks++;
        if (outs !== 7'b1100010) begin
            errors++;
            $display("FAIL rst_busy10 got %b want 1100010", outs);
        end
        rstn = 0;
        #1;
        checks++;
        if (outs !== 7'b1100000 || StallCnt !== 16'd0) begin
            errors++;
            $display("FAIL rst_abort got %b/%0d want 1100000/0", outs, StallCnt);
        end
        busyLeft = 0;
        stalls   = 0;
        @(negedge clk);
        rstn = 1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 25; i++) begin
            checks++;
            if (MdBusy !== 1'b0 || MdDone !== 1'b0) begin
                errors++;
                $display("FAIL rst_nodone%0d got %b%b want 00", i, MdBusy, MdDone);
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [6:0] e;
        for (int i = 0; i < 600; i++) begin
            IDEXMemRead = ($urandom_range(0, 2) == 0);
            IDEXRegRt   = 5'($urandom_range(0, 3));
            IFIDRegRs   = 5'($urandom_range(0, 3));
            IFIDRegRt   = 5'($urandom_range(0, 3));
            IFIDUsesRt  = 1'($urandom);
            BranchTaken = ($urandom_range(0, 7) == 0);
            IDEXMd      = ($urandom_range(0, 5) == 0);
            IDEXMdIsDiv = ($urandom_range(0, 3) == 0);
            IFIDMd      = ($urandom_range(0, 4) == 0);
            IFIDMdRead  = ($urandom_range(0, 4) == 0);
            #1;
            e = model_outs();
            checks++;
            if (outs !== e || StallCnt !== 16'(stalls)) begin
                errors++;
                $display("FAIL rand%0d got %b/%0d want %b/%0d", i, outs,
                         StallCnt, e, stalls);
            end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        rstn = 1'b1;
        clear_inputs();
        @(posedge clk);
        #1;
        test_reset();
        test_load_use();
        test_r0_and_rt();
        test_div_mfhi();
        test_mult_mult();
        test_branch();
        test_reset_mid_div();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
